// File: rtl/asteroid_renderer_if.sv
// Pixel-write and request bundle between an asteroid mover/top level and the renderer.
// Master drives update requests and consumes VGA pixel writes; slave is the renderer.
interface asteroid_renderer_if;
  logic       update;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic       moving;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output update, origin_x, origin_y, moving,
    input  vga_x, vga_y, vga_colour, plot, busy, done, overrun
  );

  modport slave (
    input  update, origin_x, origin_y, moving,
    output vga_x, vga_y, vga_colour, plot, busy, done, overrun
  );
endinterface

// File: rtl/asteroid_renderer.sv
// Erases the asteroid sprite at its last drawn position, then redraws it at the newly
// sampled origin, emitting one registered VGA pixel write per clock.
module asteroid_renderer #(
  parameter int unsigned SIZE      = 4,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input logic                clk,
  input logic                reset,
  asteroid_renderer_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StErase, StDraw, StFinish} state_e;

  localparam logic [2:0] Last = 3'(SIZE - 1);

  state_e     state_q, state_d;
  logic [7:0] old_x_q, new_x_q, base_x, vga_x_q, vga_x_d;
  logic [6:0] old_y_q, new_y_q, base_y, vga_y_q, vga_y_d;
  logic [2:0] dx_q, dy_q, colour_q, colour_d;
  logic       new_moving_q, drawn_valid_q;
  logic       plot_q, plot_d, busy_q, done_q, overrun_q;
  logic       in_pass, last_pixel, accept;
  logic [8:0] px;
  logic [7:0] py;

  assign in_pass    = (state_q == StErase) || (state_q == StDraw);
  assign last_pixel = (dx_q == Last) && (dy_q == Last);
  assign accept     = (state_q == StIdle) && bus.update;
  assign base_x     = (state_q == StErase) ? old_x_q : new_x_q;
  assign base_y     = (state_q == StErase) ? old_y_q : new_y_q;
  // Widened sums so an origin near 255/127 clips instead of wrapping to the left/top.
  assign px         = {1'b0, base_x} + {6'd0, dx_q};
  assign py         = {1'b0, base_y} + {5'd0, dy_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.update) begin
          if (drawn_valid_q)   state_d = StErase;
          else if (bus.moving) state_d = StDraw;
          else                 state_d = StFinish;
        end
      end
      StErase:  if (last_pixel) state_d = new_moving_q ? StDraw : StFinish;
      StDraw:   if (last_pixel) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    plot_d   = 1'b0;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    if (in_pass) begin
      plot_d   = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
      vga_x_d  = px[7:0];
      vga_y_d  = py[6:0];
      colour_d = (state_q == StErase) ? BG_COLOUR : FG_COLOUR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_q == StFinish);
      overrun_q <= bus.update && (state_q != StIdle);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      old_x_q       <= '0;
      old_y_q       <= '0;
      new_x_q       <= '0;
      new_y_q       <= '0;
      new_moving_q  <= 1'b0;
      drawn_valid_q <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
    end else begin
      if (accept) begin
        new_x_q      <= bus.origin_x;
        new_y_q      <= bus.origin_y;
        new_moving_q <= bus.moving;
      end
      // Both counters wrap to 0 on the last pixel, so every pass starts at the origin.
      if (in_pass) begin
        if (dx_q == Last) begin
          dx_q <= '0;
          dy_q <= (dy_q == Last) ? 3'd0 : dy_q + 3'd1;
        end else begin
          dx_q <= dx_q + 3'd1;
        end
      end else begin
        dx_q <= '0;
        dy_q <= '0;
      end
      // DRAW runs exactly when the latched request was moving.
      if (state_q == StFinish) begin
        drawn_valid_q <= new_moving_q;
        if (new_moving_q) begin
          old_x_q <= new_x_q;
          old_y_q <= new_y_q;
        end
      end
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/asteroid_renderer.md
Name: asteroid_renderer

Overview:
Draws a single asteroid sprite into the 160x120 VGA frame buffer from the position an asteroid mover produces. On each update request it erases the sprite at its previously drawn position, then draws it at the newly sampled position. It sits between one asteroid mover and the VGA adapter's pixel-write port (x, y, colour, plot) and drives one pixel write per clock.

Parameters:
SIZE, 4, sprite side length in pixels (square sprite); legal range 1..8
FG_COLOUR, 3'b111, colour written when drawing the sprite
BG_COLOUR, 3'b000, colour written when erasing the sprite
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
update  in  1  single-cycle request to redraw at the current origin
origin_x  in  8  sprite top-left x from the asteroid mover
origin_y  in  7  sprite top-left y from the asteroid mover
moving  in  1  asteroid active; when 0, the sprite is erased and not redrawn
vga_x  out  8  pixel x to the VGA adapter
vga_y  out  7  pixel y to the VGA adapter
vga_colour  out  3  pixel colour
plot  out  1  pixel write enable
busy  out  1  high while not in IDLE
done  out  1  one-cycle pulse when a redraw sequence completes
overrun  out  1  one-cycle pulse when update arrives while busy

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; vga_x=0, vga_y=0, vga_colour=0; plot=0, busy=0, done=0, overrun=0; drawn_valid=0; the old/new position registers and dx/dy counters are cleared.
- States:
  - IDLE: waits for update.
  - ERASE: runs for exactly SIZE*SIZE cycles.
  - DRAW: runs for exactly SIZE*SIZE cycles.
  - FINISH: 1 cycle; done=1, then returns to IDLE.
- IDLE, update=1 on cycle N:
  - Latch new_x=origin_x, new_y=origin_y, new_moving=moving.
  - Next state (cycle N+1):
    - ERASE if drawn_valid=1;
    - else DRAW if new_moving=1;
    - else FINISH.
- ERASE: raster scan of the old position (old_x, old_y) with vga_colour=BG_COLOUR. On the last pixel, go to DRAW if new_moving=1, else to FINISH.
- DRAW: raster scan of (new_x, new_y) with vga_colour=FG_COLOUR. On the last pixel, go to FINISH.
- FINISH:
  - If a DRAW pass ran: old_x<=new_x, old_y<=new_y, drawn_valid<=1.
  - Otherwise: drawn_valid<=0.
- Raster order:
  - dx is the inner counter and dy the outer, both 0..SIZE-1, row-major.
  - One pixel per cycle, no stalls.
  - Counters reset to 0 on each pass entry.
- Pixel arithmetic:
  - px = {1'b0, base_x} + dx, 9 bits; py = {1'b0, base_y} + dy, 8 bits.
  - Pixel is visible iff px < SCREEN_W and py < SCREEN_H.
  - Visible: plot=1, vga_x=px[7:0], vga_y=py[6:0].
  - Clipped: plot=0 and the cycle still consumes a count. Pass length is fixed regardless of clipping.
  - An origin that wrapped (e.g. 0-3 = 253) therefore clips fully; there is no wrap-around onto the left edge.
- All outputs are registered. A pixel computed in state S appears on the outputs on the next edge, so plot lags the counter by one cycle. done asserts in the cycle after the last DRAW/ERASE pixel is presented.
- Latency with drawn_valid=1 and moving=1: update at cycle N, first pixel at N+2, last at N+1+2*SIZE*SIZE, done at N+2+2*SIZE*SIZE.
- update while busy: request dropped, overrun=1 for that cycle; latched position unchanged.
- update in the same cycle as FINISH: counts as busy, so it is dropped with an overrun pulse.
- Reset mid-pass: plot drops to 0 asynchronously; drawn_valid=0. Pixels already written to the frame buffer are not erased; clearing the screen is the top level's responsibility.
- origin_x, origin_y and moving are sampled only on an accepted update; changes during a pass are ignored.

Test Plan:
- Reset, then update with origin (10,20), moving=1 -> no erase; 16 plots, colour 111, (10,20),(11,20)..(13,20),(10,21)..(13,23) in order; done 1 cycle after the 16th plot; busy high throughout.
- Then update with (13,20), moving=1 -> 16 plots colour 000 over x 10..13, y 20..23, then immediately 16 plots colour 111 over x 13..16, y 20..23; done after 32 pixel cycles.
- Update with (158,118), moving=1 -> pass still 16 cycles; plot=1 only for (158,118),(159,118),(158,119),(159,119).
- Update with origin_x=253, origin_y=5 -> 16 DRAW cycles, plot never asserted; done still pulses; drawn_valid=1 with old_x=253.
- After a drawn sprite, update with moving=0 -> 16 erase plots, colour 000, no DRAW pass, done pulses, drawn_valid=0; next update with moving=0 -> straight to FINISH, done 2 cycles after update, zero plots.
- Pulse update mid-DRAW -> overrun=1 for one cycle, pass completes unaltered; drive reset low mid-ERASE -> plot=0 and busy=0 immediately, next update performs no erase.
